// File: rtl/serial_mag_compare_ctrl_if.sv
// Handshake bundle between the bit feeder/comparator side and the serial
// magnitude-compare controller.
interface serial_mag_compare_ctrl_if #(
   parameter int CNT_W = 4
) ();
   logic             start;
   logic             in_valid;
   logic             in_aeb;
   logic             in_alb;
   logic             in_agb;
   logic             ready;
   logic             cmp_en;
   logic             busy;
   logic             done;
   logic             res_eq;
   logic             res_lt;
   logic             res_gt;
   logic             res_err;
   logic [CNT_W-1:0] bit_cnt;

   modport master (
      output start, in_valid, in_aeb, in_alb, in_agb,
      input  ready, cmp_en, busy, done, res_eq, res_lt, res_gt, res_err, bit_cnt
   );

   modport slave (
      input  start, in_valid, in_aeb, in_alb, in_agb,
      output ready, cmp_en, busy, done, res_eq, res_lt, res_gt, res_err, bit_cnt
   );
endinterface

// File: rtl/serial_mag_compare_ctrl.sv
// MSB-first serial magnitude compare controller: consumes one per-bit
// comparator result per beat and exits early on the first unequal bit.
module serial_mag_compare_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   serial_mag_compare_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state, stateNxt;
   logic [CNT_W-1:0] bitCnt;
   logic             resEq, resLt, resGt, resErr;
   logic             accept, legal, lastBit, decide;

   always_comb begin
      accept  = (state == SCAN) && bus.in_valid;
      legal   = ({bus.in_aeb, bus.in_alb, bus.in_agb} == 3'b100) ||
                ({bus.in_aeb, bus.in_alb, bus.in_agb} == 3'b010) ||
                ({bus.in_aeb, bus.in_alb, bus.in_agb} == 3'b001);
      lastBit = (bitCnt == CNT_W'(WIDTH - 1));
      // Any legal non-equal bit settles the compare; equal only on the LSB.
      decide  = accept && (!legal || bus.in_agb || bus.in_alb || lastBit);
   end

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE:    if (bus.start) stateNxt = SCAN;
         SCAN:    if (decide) stateNxt = DONE;
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         bitCnt <= '0;
         resEq  <= 1'b0;
         resLt  <= 1'b0;
         resGt  <= 1'b0;
         resErr <= 1'b0;
      end else begin
         state <= stateNxt;
         if (state == IDLE && bus.start) begin
            bitCnt <= '0;
            resEq  <= 1'b0;
            resLt  <= 1'b0;
            resGt  <= 1'b0;
            resErr <= 1'b0;
         end else if (accept) begin
            if (bitCnt != CNT_W'(WIDTH)) bitCnt <= bitCnt + CNT_W'(1);
            if (decide) begin
               resErr <= !legal;
               resGt  <= legal & bus.in_agb;
               resLt  <= legal & bus.in_alb;
               resEq  <= legal & bus.in_aeb;
            end
         end
      end
   end

   // Comparator and feeder are only enabled while beats can be accepted.
   assign bus.ready   = (state == SCAN);
   assign bus.cmp_en  = (state == SCAN);
   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.res_eq  = resEq;
   assign bus.res_lt  = resLt;
   assign bus.res_gt  = resGt;
   assign bus.res_err = resErr;
   assign bus.bit_cnt = bitCnt;
endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Scoreboard bench for serial_mag_compare_ctrl at WIDTH=4: expected results
// are queued when the deciding beat is driven and checked on done.
module tb_serial_mag_compare_ctrl;
   localparam int WIDTH = 4;
   localparam int CNT_W = 3;
   localparam logic [2:0] C_EQ = 3'b100;  // {aeb, alb, agb}
   localparam logic [2:0] C_LT = 3'b010;
   localparam logic [2:0] C_GT = 3'b001;
   localparam logic [2:0] C_BAD2 = 3'b110;
   localparam logic [2:0] C_NONE = 3'b000;

   typedef struct {
      logic [3:0]       res;   // {err, gt, lt, eq}
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   doneSeen = 0;
   int   donePushed = 0;
   logic prevDone = 1'b0;
   exp_t sbQ[$];
   exp_t lastExp;

   serial_mag_compare_ctrl_if #(.CNT_W(CNT_W)) bus ();

   serial_mag_compare_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] resVec();
      return {bus.res_err, bus.res_gt, bus.res_lt, bus.res_eq};
   endfunction

   // Monitor: pop the scoreboard on every done and check the done-cycle view.
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         exp_t e;
         doneSeen++;
         chk("done_1cyc", {31'd0, prevDone}, 32'd0);
         if (sbQ.size() == 0) begin
            chk("unexp_done", 32'd1, 32'd0);
         end else begin
            e = sbQ.pop_front();
            chk("res", {28'd0, resVec()}, {28'd0, e.res});
            chk("bit_cnt", {29'd0, bus.bit_cnt}, {29'd0, e.cnt});
            chk("done_ctl", {29'd0, bus.ready, bus.cmp_en, bus.busy}, 32'b001);
         end
      end
      prevDone <= bus.done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStart();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic beat(input logic [2:0] code);
      {bus.in_aeb, bus.in_alb, bus.in_agb} = code;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      {bus.in_aeb, bus.in_alb, bus.in_agb} = 3'b000;
   endtask

   function automatic logic [3:0] model(input logic [2:0] c, input int idx, output logic dec);
      dec = 1'b1;
      if ($countones(c) != 1) return 4'b1000;
      if (c == C_GT) return 4'b0100;
      if (c == C_LT) return 4'b0010;
      if (idx == WIDTH - 1) return 4'b0001;
      dec = 1'b0;
      return 4'b0000;
   endfunction

   // Start a compare, drive beats until the model says it is decided.
   task automatic runCmp(input string tag, input logic [2:0] codes[WIDTH]);
      logic dec;
      logic [3:0] r;
      doStart();
      chk({tag, "_scan"}, {29'd0, bus.ready, bus.cmp_en, bus.busy}, 32'b111);
      for (int i = 0; i < WIDTH; i++) begin
         r = model(codes[i], i, dec);
         if (dec) begin
            lastExp.res = r;
            lastExp.cnt = CNT_W'(i + 1);
            sbQ.push_back(lastExp);
            donePushed++;
         end
         beat(codes[i]);
         if (dec) break;
         chk({tag, "_cnt"}, {29'd0, bus.bit_cnt}, i + 1);
      end
      tick();
      chk({tag, "_hold"}, {25'd0, resVec(), bus.bit_cnt}, {25'd0, lastExp.res, lastExp.cnt});
      chk({tag, "_idle"}, {29'd0, bus.ready, bus.cmp_en, bus.busy}, 32'd0);
   endtask

   function automatic logic [31:0] allOuts();
      return {18'd0, bus.ready, bus.cmp_en, bus.busy, bus.done, bus.res_eq,
              bus.res_lt, bus.res_gt, bus.res_err, 3'd0, bus.bit_cnt};
   endfunction

   initial begin
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      {bus.in_aeb, bus.in_alb, bus.in_agb} = 3'b000;

      // 1: reset
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_outs", allOuts(), 32'd0);

      // valid in IDLE is ignored
      beat(C_EQ);
      chk("idle_valid", allOuts(), 32'd0);

      // 2: all equal
      runCmp("eq4", '{C_EQ, C_EQ, C_EQ, C_EQ});

      // 3: A=1010 B=1001 -> greater on the 3rd bit; extra valid not taken
      runCmp("gt", '{C_EQ, C_EQ, C_GT, C_EQ});
      beat(C_EQ);
      chk("gt_extra", {29'd0, bus.bit_cnt}, 32'd3);

      // 4: gaps before an alb beat
      doStart();
      tick();
      chk("gap0", {29'd0, bus.bit_cnt}, 32'd0);
      tick();
      chk("gap1", {29'd0, bus.bit_cnt}, 32'd0);
      lastExp.res = 4'b0010;
      lastExp.cnt = 3'd1;
      sbQ.push_back(lastExp);
      donePushed++;
      beat(C_LT);
      tick();
      chk("lt_hold", {25'd0, resVec(), bus.bit_cnt}, {25'd0, 4'b0010, 3'd1});

      // 5: illegal codes
      runCmp("err2", '{C_BAD2, C_EQ, C_EQ, C_EQ});
      runCmp("err0", '{C_NONE, C_EQ, C_EQ, C_EQ});
      runCmp("eqlt", '{C_EQ, C_EQ, C_EQ, C_LT});

      // 6: abort mid-scan, with start ignored and reset dominating a beat
      doStart();
      beat(C_EQ);
      beat(C_EQ);
      doStart();
      chk("start_ign", {28'd0, bus.busy, bus.bit_cnt}, {28'd0, 1'b1, 3'd2});
      rst = 1'b1;
      bus.start = 1'b1;
      {bus.in_aeb, bus.in_alb, bus.in_agb} = C_EQ;
      bus.in_valid = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      chk("abort_outs", allOuts(), 32'd0);
      tick();
      chk("abort_nodone", allOuts(), 32'd0);
      runCmp("eq_after", '{C_EQ, C_EQ, C_EQ, C_EQ});

      repeat (3) tick();
      chk("sb_empty", sbQ.size(), 32'd0);
      chk("done_count", doneSeen, donePushed);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
